// File: rtl/coin_pkg.sv
// Shared coin codes and conditioner FSM encoding for the coin-input stage.
package coin_pkg;

  localparam int unsigned COIN_W = 2;

  localparam logic [COIN_W-1:0] COIN_NONE = 2'b00;
  localparam logic [COIN_W-1:0] COIN_HALF = 2'b01;
  localparam logic [COIN_W-1:0] COIN_ONE  = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    HOLD = 2'd2
  } state_t;

endpackage

// File: rtl/coin_debounce.sv
// One coin switch: 2-flop synchronizer, counter debounce, press (0->1) event.
module coin_debounce
  import coin_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = 16,
  parameter int unsigned CNT_W      = 5
) (
  input  logic Clk,
  input  logic Reset,
  input  logic i_raw,
  output logic o_rise_c
);

  logic             r_s1;
  logic             r_s2;
  logic             r_level;
  logic             r_level_d;
  logic [CNT_W-1:0] r_cnt;

  // Level flips only after DEB_CYCLES consecutive differing samples.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      r_s1      <= 1'b0;
      r_s2      <= 1'b0;
      r_level   <= 1'b0;
      r_level_d <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_s1      <= i_raw;
      r_s2      <= r_s1;
      r_level_d <= r_level;
      if (r_s2 == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_W'(DEB_CYCLES - 1)) begin
        r_level <= r_s2;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_rise_c = r_level & ~r_level_d;

endmodule

// File: rtl/coin_in_cond.sv
// Coin-input conditioner: debounced coin events arbitrated into one-cycle
// D_in codes, with a one-deep pending slot and lockout around dispense/change.
module coin_in_cond
  import coin_pkg::*;
#(
  parameter int unsigned DEB_CYCLES  = 16,
  parameter int unsigned HOLD_CYCLES = 8,
  parameter int unsigned CNT_W       = 5
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       coin_half_raw,
  input  logic       coin_one_raw,
  input  logic       D_out,
  input  logic       D_C,
  output logic [1:0] D_in,
  output logic       busy,
  output logic       coin_drop
);

  logic w_ev_half;
  logic w_ev_one;

  coin_debounce #(.DEB_CYCLES(DEB_CYCLES), .CNT_W(CNT_W)) u_deb_half (
    .Clk      (Clk),
    .Reset    (Reset),
    .i_raw    (coin_half_raw),
    .o_rise_c (w_ev_half)
  );

  coin_debounce #(.DEB_CYCLES(DEB_CYCLES), .CNT_W(CNT_W)) u_deb_one (
    .Clk      (Clk),
    .Reset    (Reset),
    .i_raw    (coin_one_raw),
    .o_rise_c (w_ev_one)
  );

  state_t            r_state;
  logic [CNT_W-1:0]  r_hcnt;
  logic              r_pend_v;
  logic [COIN_W-1:0] r_pend_c;
  logic [COIN_W-1:0] r_din;
  logic              r_busy;
  logic              r_drop;

  logic              w_hold_req;
  logic              w_emit_ok;
  logic              w_emit_pend;
  logic              w_emit_one;
  logic              w_emit_half;
  logic              w_st_one;
  logic              w_st_half;
  logic              w_free;
  logic              w_take_one;
  logic              w_take_half;
  logic              w_drop;
  logic              w_pend_v_n;
  logic              w_hold_n;
  logic [COIN_W-1:0] w_din_n;

  // Lockout request wins over emission; the pending coin always goes first.
  assign w_hold_req  = D_out | D_C;
  assign w_emit_ok   = (r_state == IDLE) & ~w_hold_req;
  assign w_emit_pend = w_emit_ok & r_pend_v;
  assign w_emit_one  = w_emit_ok & ~r_pend_v & w_ev_one;
  assign w_emit_half = w_emit_ok & ~r_pend_v & ~w_ev_one & w_ev_half;

  // Events not emitted this cycle compete for the slot, 1-unit first.
  assign w_st_one    = w_ev_one & ~w_emit_one;
  assign w_st_half   = w_ev_half & ~w_emit_half;
  assign w_free      = ~r_pend_v | w_emit_pend;
  assign w_take_one  = w_st_one & w_free;
  assign w_take_half = w_st_half & w_free & ~w_take_one;
  assign w_drop      = (w_st_one & ~w_take_one) | (w_st_half & ~w_take_half);
  assign w_pend_v_n  = w_take_one | w_take_half | (r_pend_v & ~w_emit_pend);

  assign w_hold_n = w_hold_req |
                    ((r_state == HOLD) & (r_hcnt != CNT_W'(HOLD_CYCLES - 1)));

  assign w_din_n = w_emit_pend ? r_pend_c  :
                   w_emit_one  ? COIN_ONE  :
                   w_emit_half ? COIN_HALF : COIN_NONE;

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      r_state  <= IDLE;
      r_hcnt   <= '0;
      r_pend_v <= 1'b0;
      r_pend_c <= COIN_NONE;
      r_din    <= COIN_NONE;
      r_busy   <= 1'b0;
      r_drop   <= 1'b0;
    end else begin
      r_din    <= w_din_n;
      r_drop   <= w_drop;
      r_busy   <= w_hold_n | w_pend_v_n;
      r_pend_v <= w_pend_v_n;
      if (w_take_one) begin
        r_pend_c <= COIN_ONE;
      end else if (w_take_half) begin
        r_pend_c <= COIN_HALF;
      end
      if (w_hold_req) begin
        r_state <= HOLD;
        r_hcnt  <= '0;
      end else begin
        case (r_state)
          IDLE: if (w_din_n != COIN_NONE) r_state <= EMIT;
          EMIT: r_state <= IDLE;
          HOLD: begin
            if (r_hcnt == CNT_W'(HOLD_CYCLES - 1)) begin
              r_state <= IDLE;
            end else begin
              r_hcnt <= r_hcnt + 1'b1;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign D_in      = r_din;
  assign busy      = r_busy;
  assign coin_drop = r_drop;

endmodule
